// File: rtl/doc5503_patch_seq.sv
// DOC5503 register-patch sequencer: plays a host-loaded (addr, data, verify) table onto
// the DOC register bus, paced by the DOC clock enable, with read-back verify and retries.
module doc5503_patch_seq #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_RETRY   = 2,
    parameter logic [7:0]  OSC_EN_ADDR = 8'hE1,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clk_en_i,
    input  logic             load_we_i,
    input  logic [IDX_W-1:0] load_idx_i,
    input  logic [7:0]       load_addr_i,
    input  logic [7:0]       load_data_i,
    input  logic             load_vfy_i,
    input  logic [IDX_W:0]   len_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             cs_n_o,
    output logic             we_n_o,
    output logic [7:0]       addr_o,
    output logic [7:0]       data_o,
    input  logic [7:0]       doc_data_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [IDX_W-1:0] err_idx_o,
    output logic [7:0]       osc_en_o
);
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam int unsigned RTRY_W  = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_GAP} state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       vfy;
    } entry_t;

    entry_t              tbl_q [DEPTH];
    entry_t              cur;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [RTRY_W-1:0]   retry_q, retry_d;
    logic                pend_q, pend_d;
    logic [7:0]          rd_q, rd_d;
    logic                cs_n_q, cs_n_d;
    logic                we_n_q, we_n_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    logic [7:0]          osc_en_q, osc_en_d;

    logic                match;
    logic                last;
    logic                can_retry;

    assign cur       = tbl_q[idx_q];
    assign match     = (rd_q == cur.data);
    assign last      = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    assign can_retry = (retry_q < RTRY_W'(MAX_RETRY));

    // Patch table: loaded only while idle, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i && state_q == S_IDLE) begin
            tbl_q[load_idx_i] <= '{addr: load_addr_i, data: load_data_i, vfy: load_vfy_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state; abort beats a same-cycle strobe completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && len_i != '0) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort_i)       state_d = S_IDLE;
                else if (clk_en_i) state_d = cur.vfy ? S_READ : S_GAP;
            end
            S_READ: begin
                if (abort_i)       state_d = S_IDLE;
                else if (clk_en_i) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (abort_i)                    state_d = S_IDLE;
                else if (match || can_retry)    state_d = S_GAP;
                else                            state_d = S_IDLE;
            end
            S_GAP: begin
                if (abort_i)                    state_d = S_IDLE;
                else if (clk_en_i)              state_d = (pend_q || !last) ? S_WRITE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, decoded from the next state.
    always_comb begin
        idx_d     = idx_q;
        len_d     = len_q;
        retry_d   = retry_q;
        pend_d    = pend_q;
        rd_d      = rd_q;
        osc_en_d  = osc_en_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;
                        idx_d   = '0;
                        retry_d = '0;
                        pend_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (!abort_i && clk_en_i) begin
                    pend_d = 1'b0;
                    if (cur.addr == OSC_EN_ADDR) osc_en_d = {3'b000, cur.data[5:1]} + 8'd1;
                end
            end
            S_READ: begin
                if (!abort_i && clk_en_i) rd_d = doc_data_i;
            end
            S_CHECK: begin
                if (!abort_i && !match) begin
                    if (can_retry) begin
                        retry_d = retry_q + RTRY_W'(1);
                        pend_d  = 1'b1;
                    end else begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        done_d    = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!abort_i && clk_en_i && !pend_q) begin
                    if (last) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        retry_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cs_n_d  = !(state_d == S_WRITE || state_d == S_READ);
        we_n_d  = (state_d != S_WRITE);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_d == S_WRITE || state_d == S_READ) addr_d = tbl_q[idx_d].addr;
        if (state_d == S_WRITE)                      data_d = tbl_q[idx_d].data;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q     <= '0;
            len_q     <= '0;
            retry_q   <= '0;
            pend_q    <= 1'b0;
            rd_q      <= '0;
            cs_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            osc_en_q  <= '0;
        end else begin
            idx_q     <= idx_d;
            len_q     <= len_d;
            retry_q   <= retry_d;
            pend_q    <= pend_d;
            rd_q      <= rd_d;
            cs_n_q    <= cs_n_d;
            we_n_q    <= we_n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            osc_en_q  <= osc_en_d;
        end
    end

    assign cs_n_o    = cs_n_q;
    assign we_n_o    = we_n_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;
    assign osc_en_o  = osc_en_q;

endmodule

// File: tb/tb_doc5503_patch_seq.sv
// Directed bench for doc5503_patch_seq: bus writes checked against a scoreboard queue,
// phase timing, verify/retry, abort, len=0 and reset behaviour checked inline.
module tb_doc5503_patch_seq;
    logic       clk = 1'b0;
    logic       reset_i, clk_en_i, load_we_i, load_vfy_i, start_i, abort_i;
    logic [3:0] load_idx_i;
    logic [7:0] load_addr_i, load_data_i, doc_data_i;
    logic [4:0] len_i;
    logic       cs_n_o, we_n_o, ready_o, busy_o, done_o, error_o;
    logic [7:0] addr_o, data_o, osc_en_o;
    logic [3:0] err_idx_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        strobe_mode = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_e;

    doc5503_patch_seq dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .load_we_i(load_we_i), .load_idx_i(load_idx_i), .load_addr_i(load_addr_i),
        .load_data_i(load_data_i), .load_vfy_i(load_vfy_i), .len_i(len_i),
        .start_i(start_i), .abort_i(abort_i), .cs_n_o(cs_n_o), .we_n_o(we_n_o),
        .addr_o(addr_o), .data_o(data_o), .doc_data_i(doc_data_i), .ready_o(ready_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o),
        .osc_en_o(osc_en_o)
    );

    always #5 clk = ~clk;

    // Completed bus writes are popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset_i && !cs_n_o && !we_n_o && clk_en_i && !abort_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL bus_write unexpected observed=%h%h expected=none", addr_o, data_o);
            end else begin
                mon_e = exp_q.pop_front();
                assert ({addr_o, data_o} === mon_e) else begin
                    n_err++;
                    $error("FAIL bus_write observed=%h%h expected=%h", addr_o, data_o, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (strobe_mode) clk_en_i = (cyc % 8 == 0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [7:0] a, input logic [7:0] d,
                        input logic v);
        load_we_i = 1'b1; load_idx_i = idx; load_addr_i = a; load_data_i = d; load_vfy_i = v;
        tick();
        load_we_i = 1'b0;
    endtask

    task automatic start_seq(input logic [4:0] len);
        len_i = len;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            if (done_o) seen = 1'b1;
            else tick();
        end
        chk(tag, 64'(seen), 64'd1);
        tick();
    endtask

    // Reset-state image: {cs_n, we_n, addr, data, ready, busy, done, error, err_idx, osc}
    function automatic logic [63:0] outs();
        return 64'({cs_n_o, we_n_o, addr_o, data_o, ready_o, busy_o, done_o, error_o,
                    err_idx_o, osc_en_o});
    endfunction

    localparam logic [63:0] RST_IMG = 64'({1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
                                           4'h0, 8'h00});

    initial begin
        logic       prev_cs, prev_en, prev_busy, prev_we, seen;
        logic [15:0] prev_bus;
        int          nw, dc;

        reset_i = 1'b1; clk_en_i = 1'b1; load_we_i = 1'b0; load_idx_i = '0;
        load_addr_i = '0; load_data_i = '0; load_vfy_i = 1'b0; start_i = 1'b0;
        abort_i = 1'b0; len_i = '0; doc_data_i = '0;
        repeat (3) tick();
        chk("reset_state", outs(), RST_IMG);
        reset_i = 1'b0;

        // Three non-verify entries at full rate.
        load(4'd0, 8'hE1, 8'h3E, 1'b0);
        load(4'd1, 8'h40, 8'h55, 1'b0);
        load(4'd2, 8'hA0, 8'h00, 1'b0);
        exp_q.push_back(16'hE13E); exp_q.push_back(16'h4055); exp_q.push_back(16'hA000);
        start_seq(5'd3);
        chk("t1_write0", 64'({cs_n_o, we_n_o, addr_o, data_o}), 64'({2'b00, 16'hE13E}));
        tick();
        chk("t2_gap_osc", 64'({cs_n_o, osc_en_o}), 64'({1'b1, 8'd32}));
        tick();
        chk("t3_write1", 64'({cs_n_o, we_n_o, addr_o, data_o}), 64'({2'b00, 16'h4055}));
        tick(); tick();
        chk("t5_write2", 64'({cs_n_o, we_n_o, addr_o, data_o}), 64'({2'b00, 16'hA000}));
        tick();
        chk("t6_busy", 64'({done_o, ready_o, busy_o}), 64'({1'b0, 1'b0, 1'b1}));
        tick();
        chk("t7_done", 64'({done_o, ready_o, busy_o}), 64'({1'b1, 1'b1, 1'b0}));
        tick();
        chk("t8_done_pulse", 64'(done_o), 64'd0);

        // Strobe every 8th cycle: phases hold until a strobe with a stable bus.
        load(4'd0, 8'h40, 8'h11, 1'b0);
        load(4'd1, 8'h41, 8'h22, 1'b0);
        exp_q.push_back(16'h4011); exp_q.push_back(16'h4122);
        strobe_mode = 1'b1;
        start_seq(5'd2);
        prev_busy = 1'b0; prev_cs = 1'b1; prev_en = 1'b1; prev_we = 1'b1; prev_bus = '0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (prev_busy && !prev_cs && !prev_en)
                chk("hold_write", 64'({cs_n_o, we_n_o, addr_o, data_o}),
                    64'({1'b0, prev_we, prev_bus}));
            if (prev_busy && prev_cs && !prev_en)
                chk("hold_gap", 64'({cs_n_o, busy_o}), 64'({1'b1, 1'b1}));
            if (done_o) seen = 1'b1;
            prev_busy = busy_o; prev_cs = cs_n_o; prev_en = clk_en_i;
            prev_we = we_n_o; prev_bus = {addr_o, data_o};
            if (!seen) tick();
        end
        chk("strobe_done", 64'(seen), 64'd1);
        strobe_mode = 1'b0; clk_en_i = 1'b1;
        tick();

        // Verify pass: WRITE, READ, CHECK, GAP.
        load(4'd0, 8'h40, 8'hAA, 1'b1);
        doc_data_i = 8'hAA;
        exp_q.push_back(16'h40AA);
        start_seq(5'd1);
        tick();
        chk("vfy_read", 64'({cs_n_o, we_n_o, addr_o}), 64'({2'b01, 8'h40}));
        tick();
        chk("vfy_check", 64'({cs_n_o, busy_o}), 64'({1'b1, 1'b1}));
        tick(); tick();
        chk("vfy_done", 64'({done_o, error_o, ready_o}), 64'({1'b1, 1'b0, 1'b1}));
        tick();

        // Verify always fails: 3 writes then error on entry 0.
        doc_data_i = 8'h00;
        repeat (3) exp_q.push_back(16'h40AA);
        start_seq(5'd1);
        nw = 0; dc = 0;
        for (int c = 1; c <= 14; c++) begin
            if (!we_n_o) nw++;
            if (done_o) dc = c;
            tick();
        end
        chk("retry_writes", 64'(nw), 64'd3);
        chk("retry_done_cyc", 64'(dc), 64'd12);
        chk("retry_error", 64'({error_o, err_idx_o}), 64'({1'b1, 4'd0}));
        doc_data_i = 8'hAA;
        exp_q.push_back(16'h40AA);
        start_seq(5'd1);
        chk("error_cleared", 64'(error_o), 64'd0);
        wait_done("retry_clear_done", 20);

        // Abort during the second write; busy-time load and start are ignored.
        load(4'd0, 8'h50, 8'h01, 1'b0);
        load(4'd1, 8'hE1, 8'h10, 1'b0);
        load(4'd2, 8'h52, 8'h03, 1'b0);
        exp_q.push_back(16'h5001);
        start_seq(5'd3);
        tick();
        load_we_i = 1'b1; load_idx_i = 4'd0; load_addr_i = 8'h77; load_data_i = 8'h77;
        load_vfy_i = 1'b0; start_i = 1'b1; len_i = 5'd1;
        tick();
        load_we_i = 1'b0; start_i = 1'b0;
        chk("abort_in_write", 64'({cs_n_o, we_n_o, addr_o}), 64'({2'b00, 8'hE1}));
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_idle", 64'({cs_n_o, we_n_o, ready_o, busy_o, done_o}), 64'(5'b11100));
        chk("abort_osc", 64'(osc_en_o), 64'd32);
        seen = 1'b0;
        repeat (4) begin tick(); if (done_o || !cs_n_o) seen = 1'b1; end
        chk("abort_quiet", 64'(seen), 64'd0);
        exp_q.push_back(16'h5001);
        start_seq(5'd1);
        wait_done("ignored_load_done", 10);

        // len=0: done pulse, no bus activity.
        start_seq(5'd0);
        chk("len0_done", 64'({done_o, cs_n_o, ready_o}), 64'(3'b111));
        tick();
        chk("len0_pulse", 64'({done_o, cs_n_o}), 64'(2'b01));

        // Reset in the middle of a READ.
        load(4'd0, 8'h40, 8'hAA, 1'b1);
        exp_q.push_back(16'h40AA);
        start_seq(5'd1);
        tick();
        chk("rst_in_read", 64'({cs_n_o, we_n_o}), 64'(2'b01));
        reset_i = 1'b1;
        tick();
        chk("rst_mid_read", outs(), RST_IMG);
        reset_i = 1'b0;
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
